// File: rtl/k12a_pc_unit.sv
// k12a program counter / sequencing stage: increment, skip, jump,
// call/return with a circular return-address stack, PC store to bus.
module k12a_pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          STACK_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_condition,
  input  logic        cond_latch,
  input  logic        pc_inc,
  input  logic        pc_skip,
  input  logic        jump_hi_load,
  input  logic        jump_lo_load,
  input  logic        jump_commit,
  input  logic        jump_cond,
  input  logic        jump_link,
  input  logic        pc_ret,
  input  logic        pc_store_hi,
  input  logic        pc_store_lo,
  inout  wire  [7:0]  data_bus,
  output logic [15:0] pc,
  output logic        cond,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [15:0]   r_pc;
  logic          r_cond;
  logic [7:0]    r_jump_hi;
  logic [7:0]    r_jump_lo;
  logic [PW-1:0] r_wp;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [15:0]   r_stack [STACK_DEPTH];

  logic          w_taken;
  logic          w_push;
  logic          w_pop;
  logic          w_unf;
  logic          w_full;
  logic [15:0]   w_pc_inc;
  logic [15:0]   w_pc_skip;
  logic [15:0]   w_top;
  logic [15:0]   w_pc_next;

  assign w_taken   = ~jump_cond | r_cond;
  assign w_full    = (r_depth == FULL);
  assign w_pc_inc  = r_pc + 16'd1;
  assign w_pc_skip = r_pc + (r_cond ? 16'd2 : 16'd1);
  assign w_top     = r_stack[r_wp - PW'(1)];
  assign w_push    = jump_commit & w_taken & jump_link;
  assign w_pop     = ~jump_commit & pc_ret & (r_depth != '0);
  assign w_unf     = ~jump_commit & pc_ret & (r_depth == '0);

  // one PC source per cycle, highest-priority strobe wins outright
  always_comb begin
    w_pc_next = r_pc;
    priority case (1'b1)
      jump_commit: w_pc_next = w_taken ? {r_jump_hi, r_jump_lo} : w_pc_inc;
      pc_ret:      w_pc_next = w_pop ? w_top : w_pc_inc;
      pc_skip:     w_pc_next = w_pc_skip;
      pc_inc:      w_pc_next = w_pc_inc;
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_VECTOR;
      r_cond    <= 1'b0;
      r_jump_hi <= 8'h00;
      r_jump_lo <= 8'h00;
      r_wp      <= '0;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (cond_latch)   r_cond    <= alu_condition;
      if (jump_hi_load) r_jump_hi <= data_bus;
      if (jump_lo_load) r_jump_lo <= data_bus;
      // when full the write pointer sits on the oldest entry
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
        if (w_full) r_ovf   <= 1'b1;
        else        r_depth <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_wp    <= r_wp - PW'(1);
        r_depth <= r_depth - DW'(1);
      end
      if (w_unf) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_stack[r_wp] <= w_pc_inc;
  end

  assign data_bus = pc_store_hi ? r_pc[15:8] :
                    pc_store_lo ? r_pc[7:0]  : 8'bzzzz_zzzz;

  assign pc              = r_pc;
  assign cond            = r_cond;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_k12a_pc_unit.sv
// Directed self-checking bench for k12a_pc_unit.
// Idle bus floats to a pull-high value (8'hFF).
module tb_k12a_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_condition;
  logic        cond_latch;
  logic        pc_inc;
  logic        pc_skip;
  logic        jump_hi_load;
  logic        jump_lo_load;
  logic        jump_commit;
  logic        jump_cond;
  logic        jump_link;
  logic        pc_ret;
  logic        pc_store_hi;
  logic        pc_store_lo;
  tri1  [7:0]  data_bus;
  logic [15:0] pc;
  logic        cond;
  logic        stack_overflow;
  logic        stack_underflow;

  logic        tb_drv;
  logic [7:0]  tb_val;
  int          checks = 0;
  int          errors = 0;

  assign data_bus = tb_drv ? tb_val : 8'bzzzz_zzzz;

  always #5 clock = ~clock;

  k12a_pc_unit #(
    .RESET_VECTOR(16'h0100),
    .STACK_DEPTH (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_condition  (alu_condition),
    .cond_latch     (cond_latch),
    .pc_inc         (pc_inc),
    .pc_skip        (pc_skip),
    .jump_hi_load   (jump_hi_load),
    .jump_lo_load   (jump_lo_load),
    .jump_commit    (jump_commit),
    .jump_cond      (jump_cond),
    .jump_link      (jump_link),
    .pc_ret         (pc_ret),
    .pc_store_hi    (pc_store_hi),
    .pc_store_lo    (pc_store_lo),
    .data_bus       (data_bus),
    .pc             (pc),
    .cond           (cond),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    alu_condition = 0; cond_latch = 0;
    pc_inc = 0; pc_skip = 0;
    jump_hi_load = 0; jump_lo_load = 0;
    jump_commit = 0; jump_cond = 0;
    jump_link = 0; pc_ret = 0;
    pc_store_hi = 0; pc_store_lo = 0;
    tb_drv = 0; tb_val = 8'h00;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic load_jump(input logic [15:0] v);
    tb_drv = 1; tb_val = v[15:8]; jump_hi_load = 1;
    tick();
    jump_hi_load = 0; tb_val = v[7:0]; jump_lo_load = 1;
    tick();
    jump_lo_load = 0; tb_drv = 0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_jump(v);
    jump_commit = 1;
    tick();
    jump_commit = 0;
  endtask

  task automatic set_cond(input logic b);
    alu_condition = b; cond_latch = 1;
    tick();
    cond_latch = 0; alu_condition = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0100) begin
      errors++; $display("FAIL reset_pc got %h want 0100", pc);
    end
    checks++;
    if ({cond, stack_overflow, stack_underflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {cond, stack_overflow, stack_underflow});
    end
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL reset_bus got %h want FF(idle)", data_bus);
    end
  endtask

  task automatic test_arith();
    set_pc(16'hFFFF);
    pc_inc = 1; tick(); pc_inc = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL inc_wrap got %h want 0000", pc);
    end
    set_cond(1);
    set_pc(16'hFFFF);
    pc_skip = 1; tick(); pc_skip = 0;
    checks++;
    if (pc !== 16'h0001) begin
      errors++; $display("FAIL skip_wrap1 got %h want 0001", pc);
    end
    set_pc(16'hFFFE);
    pc_skip = 1; tick(); pc_skip = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL skip_wrap2 got %h want 0000", pc);
    end
    set_cond(0);
    set_pc(16'h0010);
    pc_skip = 1; tick(); pc_skip = 0;
    checks++;
    if (pc !== 16'h0011) begin
      errors++; $display("FAIL skip_nocond got %h want 0011", pc);
    end
    tick();
    checks++;
    if (pc !== 16'h0011) begin
      errors++; $display("FAIL hold got %h want 0011", pc);
    end
  endtask

  task automatic test_call_ret();
    set_pc(16'h0050);
    load_jump(16'h1234);
    jump_commit = 1; jump_link = 1;
    tick();
    jump_commit = 0; jump_link = 0;
    checks++;
    if (pc !== 16'h1234) begin
      errors++; $display("FAIL call_pc got %h want 1234", pc);
    end
    pc_ret = 1; tick(); pc_ret = 0;
    checks++;
    if (pc !== 16'h0051) begin
      errors++; $display("FAIL ret_pc got %h want 0051", pc);
    end
  endtask

  task automatic test_priority();
    set_pc(16'h0040);
    jump_commit = 1; jump_link = 1;
    tick();
    jump_commit = 0; jump_link = 0;
    pc_ret = 1; pc_skip = 1; pc_inc = 1;
    tick();
    pc_ret = 0; pc_skip = 0; pc_inc = 0;
    checks++;
    if (pc !== 16'h0041) begin
      errors++; $display("FAIL prio_ret got %h want 0041", pc);
    end
    jump_commit = 1; pc_ret = 1; pc_inc = 1;
    tick();
    jump_commit = 0; pc_ret = 0; pc_inc = 0;
    checks++;
    if (pc !== 16'h0040 || stack_underflow !== 1'b0) begin
      errors++;
      $display("FAIL prio_jump got pc=%h unf=%b want 0040 0",
               pc, stack_underflow);
    end
  endtask

  task automatic test_cond_jump();
    set_cond(0);
    set_pc(16'h0200);
    jump_commit = 1; jump_cond = 1; jump_link = 1;
    cond_latch = 1; alu_condition = 1;
    tick();
    clr();
    checks++;
    if (pc !== 16'h0201 || cond !== 1'b1) begin
      errors++;
      $display("FAIL cjump_old got pc=%h cond=%b want 0201 1", pc, cond);
    end
    jump_commit = 1; jump_cond = 1;
    tick();
    clr();
    checks++;
    if (pc !== 16'h0200) begin
      errors++; $display("FAIL cjump_taken got %h want 0200", pc);
    end
    pc_ret = 1; tick(); pc_ret = 0;
    checks++;
    if (pc !== 16'h0201 || stack_underflow !== 1'b1) begin
      errors++;
      $display("FAIL nopush_unf got pc=%h unf=%b want 0201 1",
               pc, stack_underflow);
    end
  endtask

  task automatic test_stack();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h1401; exp_ret[1] = 16'h1301;
    exp_ret[2] = 16'h1201; exp_ret[3] = 16'h1101;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_pc(16'h1000 + 16'(i * 256));
      load_jump(16'h8000);
      jump_commit = 1; jump_link = 1;
      tick();
      jump_commit = 0; jump_link = 0;
      if (i == 3) begin
        checks++;
        if (stack_overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_early got %b want 0", stack_overflow);
        end
      end
    end
    checks++;
    if (stack_overflow !== 1'b1 || pc !== 16'h8000) begin
      errors++;
      $display("FAIL ovf got ovf=%b pc=%h want 1 8000", stack_overflow, pc);
    end
    for (int i = 0; i < 4; i++) begin
      pc_ret = 1; tick(); pc_ret = 0;
      checks++;
      if (pc !== exp_ret[i]) begin
        errors++; $display("FAIL ret%0d got %h want %h", i, pc, exp_ret[i]);
      end
    end
    checks++;
    if (stack_underflow !== 1'b0) begin
      errors++; $display("FAIL unf_early got %b want 0", stack_underflow);
    end
    pc_ret = 1; tick(); pc_ret = 0;
    checks++;
    if (pc !== 16'h1102 || stack_underflow !== 1'b1) begin
      errors++;
      $display("FAIL unf got pc=%h unf=%b want 1102 1", pc, stack_underflow);
    end
    checks++;
    if (stack_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", stack_overflow);
    end
  endtask

  task automatic test_bus();
    set_pc(16'hABCD);
    pc_store_hi = 1; pc_inc = 1;
    #1;
    checks++;
    if (data_bus !== 8'hAB) begin
      errors++; $display("FAIL bus_hi got %h want AB", data_bus);
    end
    tick();
    pc_store_hi = 0; pc_inc = 0;
    pc_store_lo = 1;
    #1;
    checks++;
    if (data_bus !== 8'hCE) begin
      errors++; $display("FAIL bus_lo got %h want CE", data_bus);
    end
    pc_store_hi = 1;
    #1;
    checks++;
    if (data_bus !== 8'hAB) begin
      errors++; $display("FAIL bus_both got %h want AB", data_bus);
    end
    pc_store_hi = 0; pc_store_lo = 0;
    #1;
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL bus_idle got %h want FF(idle)", data_bus);
    end
  endtask

  initial begin
    reset = 1;
    clr();
    test_reset();
    test_arith();
    test_call_ret();
    test_priority();
    test_cond_jump();
    test_stack();
    test_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
